// File: rtl/bg_line_renderer.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | bg_line_renderer: double-banked background tile line fetch and display   |
// | Revision: 1.0                                                            |
// +--------------------------------------------------------------------------+
module bg_line_renderer (
  input  logic        clk,
  input  logic        reset,
  input  logic        line_start,
  input  logic [8:0]  line_num,
  output logic [8:0]  tb_addr,
  input  logic [31:0] tb_rdata,
  output logic [10:0] tg_addr,
  input  logic [31:0] tg_rdata,
  input  logic [9:0]  pix_x,
  output logic [2:0]  pix_index,
  output logic        busy,
  output logic        done
);

  typedef enum logic [2:0] {
    IDLE       = 3'd0,
    RD_TILE    = 3'd1,
    LATCH_TILE = 3'd2,
    RD_GFX     = 3'd3,
    WR_PIX     = 3'd4
  } state_t;

  state_t      state_q;
  logic        front_q;
  logic [8:0]  base_q;
  logic [4:0]  r_q;
  logic [4:0]  col_q;
  logic [1:0]  w_q;
  logic [3:0]  pat_q;
  logic [8:0]  tb_addr_q;
  logic [10:0] tg_addr_q;
  logic [2:0]  pix_index_q;

  logic [23:0] bank_q [2][80];

  logic        start_ok_d;
  logic        last_wr_d;
  logic        bank_we_d;
  logic [8:0]  base_d;
  logic [23:0] unpacked_d;
  logic [23:0] front_word_d;
  logic        pix_in_range_d;
  logic [4:0]  sel_d;
  logic        unused_ok;

  assign start_ok_d     = line_start && (line_num < 9'd480);
  assign last_wr_d      = (state_q == WR_PIX) && (col_q == 5'd19) && (w_q == 2'd3);
  assign bank_we_d      = (state_q == WR_PIX);
  // row*20 as row*16 + row*4
  assign base_d         = {1'b0, line_num[8:5], 4'd0} + {3'd0, line_num[8:5], 2'd0};
  assign pix_in_range_d = (pix_x < 10'd640);
  assign sel_d          = {1'b0, pix_x[2:0], 1'b0} + {2'b00, pix_x[2:0]};

  assign unused_ok = ^{tb_rdata[31:4], tg_rdata[31], tg_rdata[27], tg_rdata[23],
                       tg_rdata[19], tg_rdata[15], tg_rdata[11], tg_rdata[7], tg_rdata[3]};

  always_comb begin
    unpacked_d = '0;
    for (int k = 0; k < 8; k++) begin
      unpacked_d[3*k +: 3] = tg_rdata[4*k +: 3];
    end
  end

  always_comb begin
    front_word_d = '0;
    if (pix_in_range_d) begin
      front_word_d = bank_q[front_q][pix_x[9:3]];
    end
  end

  // A swap on the final write cycle still lets that write land, so the
  // freshly completed bank is the one that becomes front.
  always_ff @(posedge clk) begin
    if (bank_we_d) begin
      bank_q[~front_q][{col_q, w_q}] <= unpacked_d;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q   <= IDLE;
      front_q   <= 1'b0;
      base_q    <= '0;
      r_q       <= '0;
      col_q     <= '0;
      w_q       <= '0;
      pat_q     <= '0;
      tb_addr_q <= '0;
      tg_addr_q <= '0;
    end else if (start_ok_d) begin
      front_q   <= ~front_q;
      base_q    <= base_d;
      r_q       <= line_num[4:0];
      col_q     <= '0;
      w_q       <= '0;
      tb_addr_q <= base_d;
      state_q   <= RD_TILE;
    end else begin
      case (state_q)
        RD_TILE: state_q <= LATCH_TILE;
        LATCH_TILE: begin
          pat_q     <= tb_rdata[3:0];
          w_q       <= '0;
          tg_addr_q <= {tb_rdata[3:0], r_q, 2'd0};
          state_q   <= RD_GFX;
        end
        RD_GFX: state_q <= WR_PIX;
        WR_PIX: begin
          if (w_q != 2'd3) begin
            w_q       <= w_q + 2'd1;
            tg_addr_q <= {pat_q, r_q, w_q + 2'd1};
            state_q   <= RD_GFX;
          end else if (col_q != 5'd19) begin
            col_q     <= col_q + 5'd1;
            tb_addr_q <= base_q + {4'd0, col_q + 5'd1};
            state_q   <= RD_TILE;
          end else begin
            state_q <= IDLE;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      pix_index_q <= '0;
    end else if (pix_in_range_d) begin
      pix_index_q <= front_word_d[sel_d +: 3];
    end else begin
      pix_index_q <= '0;
    end
  end

  assign tb_addr   = tb_addr_q;
  assign tg_addr   = tg_addr_q;
  assign pix_index = pix_index_q;
  assign busy      = (state_q != IDLE);
  assign done      = last_wr_d && !start_ok_d;

endmodule
`default_nettype wire
